// File: rtl/md_sched.sv
// Multiply/divide controller for the EX stage: owns HI/LO and stalls the D stage while busy.
// Optional MD_MADD_EN adds madd/maddu (ops 7/8) that accumulate into {HI,LO}.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, a_mag, b_mag, uq, ur, sq, sr, uq_u, ur_u;

  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced non-zero so the dividers never see 0; the zero case suppresses the write instead.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign a_mag  = a[31] ? (~a + 32'd1) : a;
  assign b_mag  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign uq     = a_mag / b_mag;
  assign ur     = a_mag % b_mag;
  assign sq     = (a[31] ^ b_safe[31]) ? (~uq + 32'd1) : uq;
  assign sr     = a[31] ? (~ur + 32'd1) : ur;
  assign uq_u   = a / b_safe;
  assign ur_u   = a % b_safe;

  assign accept = start & ~cancel & (state_q == IDLE);
  assign busy   = (state_q == RUN);
  assign stall  = d_md & (busy | (start & ~cancel & (op != 4'd0)));
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_lo_d = (op == OP_DIV) ? sq : uq_u;
              pend_hi_d = (op == OP_DIV) ? sr : ur_u;
              pend_wr_d = (b != 32'd0);
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + ((op == OP_MADD) ? prod_s : prod_u);
              pend_wr_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule
